// File: rtl/mesh_pkg.sv
// Shared mesh constants and packet-type encodings used by the replication sequencer.
package mesh_pkg;
  localparam int COORD_W  = 3;
  localparam int NODE_W   = 6;
  localparam int MESH_DIM = 8;

  localparam logic [1:0] PKT_UNI   = 2'b00;
  localparam logic [1:0] PKT_COL   = 2'b01;
  localparam logic [1:0] PKT_ROW   = 2'b10;
  localparam logic [1:0] PKT_BCAST = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } rep_state_t;
endpackage

// File: rtl/mcast_cursor.sv
// Combinational sweep helper: next position, sweep end and two-step skip lookahead
// that decides whether the current copy is the final one of the packet.
module mcast_cursor
  import mesh_pkg::*;
#(
  parameter logic [COORD_W-1:0] LOCAL_X   = 3'd0,
  parameter logic [COORD_W-1:0] LOCAL_Y   = 3'd0,
  parameter bit                 SKIP_SELF = 1'b1
) (
  input  logic [1:0]        typ,
  input  logic [NODE_W-1:0] cur,
  input  logic              skip_en,
  input  logic [NODE_W-1:0] skip_node,
  output logic [NODE_W-1:0] nxt,
  output logic              cur_end,
  output logic              skip_cur,
  output logic              last
);
  localparam logic [NODE_W-1:0] SELF = {LOCAL_Y, LOCAL_X};

  function automatic logic [NODE_W-1:0] step_pos(input logic [1:0] t, input logic [NODE_W-1:0] c);
    logic [COORD_W-1:0] cy;
    logic [COORD_W-1:0] cx;
    cy = c[NODE_W-1:COORD_W];
    cx = c[COORD_W-1:0];
    case (t)
      PKT_COL:   step_pos = {cy + 3'd1, cx};
      PKT_ROW:   step_pos = {cy, cx + 3'd1};
      PKT_BCAST: step_pos = c + 6'd1;
      default:   step_pos = c;
    endcase
  endfunction

  function automatic logic is_end(input logic [1:0] t, input logic [NODE_W-1:0] c);
    case (t)
      PKT_COL:   is_end = (c[NODE_W-1:COORD_W] == 3'd7);
      PKT_ROW:   is_end = (c[COORD_W-1:0] == 3'd7);
      PKT_BCAST: is_end = (c == 6'd63);
      default:   is_end = 1'b1;
    endcase
  endfunction

  function automatic logic is_skip(input logic [1:0] t, input logic [NODE_W-1:0] c,
                                   input logic en, input logic [NODE_W-1:0] node);
    is_skip = (t != PKT_UNI) && ((en && (c == node)) || (SKIP_SELF && (c == SELF)));
  endfunction

  logic [NODE_W-1:0] n1;
  logic [NODE_W-1:0] n2;
  logic              sk1;
  logic              sk2;

  assign n1       = step_pos(typ, cur);
  assign n2       = step_pos(typ, n1);
  assign nxt      = n1;
  assign cur_end  = is_end(typ, cur);
  assign skip_cur = is_skip(typ, cur, skip_en, skip_node);
  assign sk1      = is_skip(typ, n1, skip_en, skip_node);
  assign sk2      = is_skip(typ, n2, skip_en, skip_node);

  // At most two positions are ever skipped, so looking two ahead is enough.
  assign last = (typ == PKT_UNI) || cur_end ||
                (sk1 && (is_end(typ, n1) || (sk2 && is_end(typ, n2))));
endmodule

// File: rtl/mcast_replicate_ctrl.sv
// Multicast/broadcast replication sequencer: accepts one packet, then emits one
// copy per non-skipped destination of its row, column or full-mesh sweep.
module mcast_replicate_ctrl
  import mesh_pkg::*;
#(
  parameter logic [COORD_W-1:0] LOCAL_X   = 3'd0,
  parameter logic [COORD_W-1:0] LOCAL_Y   = 3'd0,
  parameter int                 DATA_W    = 32,
  parameter bit                 SKIP_SELF = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [1:0]        in_type,
  input  logic [NODE_W-1:0] in_tgt,
  input  logic [DATA_W-1:0] in_data,
  input  logic              skip_en,
  input  logic [NODE_W-1:0] skip_node,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [NODE_W-1:0] out_tgt,
  output logic [1:0]        out_type,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [6:0]        copy_cnt
);
  rep_state_t        state_q;
  rep_state_t        state_d;
  logic [NODE_W-1:0] cur_q;
  logic [NODE_W-1:0] cur_init;
  logic [1:0]        type_q;
  logic [DATA_W-1:0] data_q;
  logic              skip_en_q;
  logic [NODE_W-1:0] skip_node_q;
  logic [6:0]        cnt_q;

  logic [NODE_W-1:0] nxt;
  logic              cur_end;
  logic              skip_cur;
  logic              last;
  logic              accept;
  logic              hs;

  mcast_cursor #(
    .LOCAL_X  (LOCAL_X),
    .LOCAL_Y  (LOCAL_Y),
    .SKIP_SELF(SKIP_SELF)
  ) u_cursor (
    .typ      (type_q),
    .cur      (cur_q),
    .skip_en  (skip_en_q),
    .skip_node(skip_node_q),
    .nxt      (nxt),
    .cur_end  (cur_end),
    .skip_cur (skip_cur),
    .last     (last)
  );

  assign in_rdy   = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_SEND);
  assign out_vld  = busy && !skip_cur;
  assign out_last = out_vld && last;
  assign out_tgt  = cur_q;
  assign out_type = type_q;
  assign out_data = data_q;
  assign copy_cnt = cnt_q;
  assign accept   = in_rdy && in_vld;
  assign hs       = out_vld && out_rdy;

  always_comb begin
    cur_init = in_tgt;
    case (in_type)
      PKT_COL:   cur_init = {3'd0, in_tgt[COORD_W-1:0]};
      PKT_ROW:   cur_init = {in_tgt[NODE_W-1:COORD_W], 3'd0};
      PKT_BCAST: cur_init = '0;
      default:   cur_init = in_tgt;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_vld) state_d = ST_SEND;
      ST_SEND: if (hs && last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      type_q      <= '0;
      data_q      <= '0;
      skip_en_q   <= 1'b0;
      skip_node_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cur_q       <= cur_init;
        type_q      <= in_type;
        data_q      <= in_data;
        skip_en_q   <= skip_en;
        skip_node_q <= skip_node;
        cnt_q       <= '0;
      end else if (busy) begin
        // Skipped positions burn one cycle; emitted ones wait for the handshake.
        if (skip_cur || (hs && !last)) cur_q <= nxt;
        if (hs) cnt_q <= cnt_q + 7'd1;
      end
    end
  end
endmodule

// File: tb/tb_mcast_replicate_ctrl.sv
// Scoreboard bench: two node instances, (x2,y3) and (x7,y7), both skipping self.
module tb_mcast_replicate_ctrl;
  import mesh_pkg::*;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic vld_a = 1'b0, vld_b = 1'b0;
  logic [1:0] in_type = '0;
  logic [5:0] in_tgt = '0;
  logic [DW-1:0] in_data = '0;
  logic skip_en = 1'b0;
  logic [5:0] skip_node = '0;
  logic out_rdy = 1'b0;

  logic rdy_a, ovld_a, last_a, busy_a, rdy_b, ovld_b, last_b, busy_b;
  logic [5:0] tgt_a, tgt_b;
  logic [1:0] typ_a, typ_b;
  logic [DW-1:0] data_a, data_b;
  logic [6:0] cnt_a, cnt_b;

  mcast_replicate_ctrl #(.LOCAL_X(3'd2), .LOCAL_Y(3'd3), .DATA_W(DW), .SKIP_SELF(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_vld(vld_a), .in_rdy(rdy_a), .in_type(in_type),
    .in_tgt(in_tgt), .in_data(in_data), .skip_en(skip_en), .skip_node(skip_node),
    .out_vld(ovld_a), .out_rdy(out_rdy), .out_tgt(tgt_a), .out_type(typ_a),
    .out_data(data_a), .out_last(last_a), .busy(busy_a), .copy_cnt(cnt_a));

  mcast_replicate_ctrl #(.LOCAL_X(3'd7), .LOCAL_Y(3'd7), .DATA_W(DW), .SKIP_SELF(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_vld(vld_b), .in_rdy(rdy_b), .in_type(in_type),
    .in_tgt(in_tgt), .in_data(in_data), .skip_en(skip_en), .skip_node(skip_node),
    .out_vld(ovld_b), .out_rdy(out_rdy), .out_tgt(tgt_b), .out_type(typ_b),
    .out_data(data_b), .out_last(last_b), .busy(busy_b), .copy_cnt(cnt_b));

  bit sel = 1'b0;
  logic o_rdy, o_vld, o_last, o_busy;
  logic [5:0] o_tgt;
  logic [1:0] o_type;
  logic [DW-1:0] o_data;
  logic [6:0] o_cnt;
  assign o_rdy  = sel ? rdy_b  : rdy_a;
  assign o_vld  = sel ? ovld_b : ovld_a;
  assign o_last = sel ? last_b : last_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_tgt  = sel ? tgt_b  : tgt_a;
  assign o_type = sel ? typ_b  : typ_a;
  assign o_data = sel ? data_b : data_a;
  assign o_cnt  = sel ? cnt_b  : cnt_a;

  typedef struct packed {logic [5:0] tgt; logic is_last;} exp_t;
  exp_t q[$];
  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [DW-1:0] exp_data;
  logic [1:0] exp_type;
  int exp_copies;

  // Reference sweep: push every non-skipped destination; return positions visited.
  function automatic int build(input logic [1:0] t, input logic [5:0] tgt, input logic sken,
                               input logic [5:0] skn, input logic [5:0] self);
    logic [5:0] pos[$];
    logic [5:0] p;
    int vis;
    vis = 0;
    exp_copies = 0;
    case (t)
      PKT_UNI: pos.push_back(tgt);
      PKT_COL: for (int y = 0; y < 8; y++) begin p = {y[2:0], tgt[2:0]}; pos.push_back(p); end
      PKT_ROW: for (int x = 0; x < 8; x++) begin p = {tgt[5:3], x[2:0]}; pos.push_back(p); end
      default: for (int i = 0; i < 64; i++) begin p = i[5:0]; pos.push_back(p); end
    endcase
    for (int i = 0; i < pos.size(); i++) begin
      if (t == PKT_UNI || !((sken && pos[i] == skn) || pos[i] == self)) begin
        q.push_back('{tgt: pos[i], is_last: 1'b0});
        exp_copies++;
        vis = i + 1;
      end
    end
    q[q.size()-1].is_last = 1'b1;
    return vis;
  endfunction

  task automatic start_pkt(input bit s, input logic [1:0] t, input logic [5:0] tgt,
                           input logic [DW-1:0] d, input logic sken, input logic [5:0] skn,
                           input bit hold, output int nvis);
    @(negedge clk);
    sel = s; in_type = t; in_tgt = tgt; in_data = d; skip_en = sken; skip_node = skn;
    out_rdy = 1'b0;
    if (s) vld_b = 1'b1; else vld_a = 1'b1;
    #1;
    cmp_cnt++;
    if (o_rdy !== 1'b1) begin err_cnt++; $display("FAIL accept_rdy: got %b want 1", o_rdy); end
    exp_data = d; exp_type = t;
    nvis = build(t, tgt, sken, skn, s ? 6'o77 : 6'o32);
    @(negedge clk);
    if (!hold) begin
      // Post-acceptance input changes must not reach the sweep.
      vld_a = 1'b0; vld_b = 1'b0;
      skip_en = ~sken; skip_node = ~skn; in_data = ~d; in_type = ~t; in_tgt = ~tgt;
    end
  endtask

  task automatic sweep(input bit rnd, input int max_hs, output int cycles);
    logic [5:0] held_tgt;
    bit stalled;
    exp_t e;
    int hs;
    cycles = 0; hs = 0; stalled = 0; held_tgt = '0;
    while (q.size() > 0 && hs < max_hs && cycles < 300) begin
      out_rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      cmp_cnt++;
      if (o_busy !== 1'b1 || o_rdy !== 1'b0) begin
        err_cnt++; $display("FAIL busy_in_send: busy=%b in_rdy=%b want 1/0", o_busy, o_rdy);
      end
      if (stalled) begin
        cmp_cnt++;
        if (o_vld !== 1'b1 || o_tgt !== held_tgt) begin
          err_cnt++; $display("FAIL stall_hold: vld=%b tgt=%o want 1/%o", o_vld, o_tgt, held_tgt);
        end
      end
      if (o_vld === 1'b1) begin
        e = q[0];
        cmp_cnt++;
        if (o_tgt !== e.tgt || o_last !== e.is_last || o_data !== exp_data || o_type !== exp_type) begin
          err_cnt++;
          $display("FAIL copy: tgt=%o last=%b data=%h type=%b want %o/%b/%h/%b",
                   o_tgt, o_last, o_data, o_type, e.tgt, e.is_last, exp_data, exp_type);
        end
        if (out_rdy) begin void'(q.pop_front()); hs++; end
      end
      stalled = (o_vld === 1'b1) && !out_rdy;
      held_tgt = o_tgt;
      cycles++;
      @(negedge clk);
    end
    out_rdy = 1'b0;
    if (cycles >= 300) begin
      err_cnt++; $display("FAIL sweep_timeout: %0d entries left, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    cmp_cnt++;
    if ({rdy_a, ovld_a, last_a, busy_a, cnt_a, tgt_a, typ_a, data_a} !== {4'b1000, 7'd0, 6'd0, 2'd0, 32'd0} ||
        {rdy_b, ovld_b, last_b, busy_b, cnt_b, tgt_b, typ_b, data_b} !== {4'b1000, 7'd0, 6'd0, 2'd0, 32'd0}) begin
      err_cnt++;
      $display("FAIL reset_state: a rdy/vld/last/busy=%b%b%b%b cnt=%0d b=%b%b%b%b cnt=%0d want 1000/0",
               rdy_a, ovld_a, last_a, busy_a, cnt_a, rdy_b, ovld_b, last_b, busy_b, cnt_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_packet(input string name, input bit s, input logic [1:0] t,
                             input logic [5:0] tgt, input logic [DW-1:0] d,
                             input logic sken, input logic [5:0] skn, input int want_copies);
    int nvis, cyc;
    start_pkt(s, t, tgt, d, sken, skn, 1'b0, nvis);
    sweep(1'b0, 1000, cyc);
    #1;
    cmp_cnt++;
    if (exp_copies != want_copies || o_cnt !== 7'(want_copies)) begin
      err_cnt++; $display("FAIL %s copy_cnt: got %0d model %0d want %0d", name, o_cnt, exp_copies, want_copies);
    end
    cmp_cnt++;
    if (cyc != nvis) begin err_cnt++; $display("FAIL %s sweep_cycles: got %0d want %0d", name, cyc, nvis); end
    cmp_cnt++;
    if (o_rdy !== 1'b1 || o_busy !== 1'b0 || o_vld !== 1'b0) begin
      err_cnt++; $display("FAIL %s back_idle: rdy=%b busy=%b vld=%b want 1/0/0", name, o_rdy, o_busy, o_vld);
    end
  endtask

  task automatic test_unicast();
    test_packet("uni", 1'b0, PKT_UNI, 6'o52, 32'hA5A5_0001, 1'b0, 6'o00, 1);
    test_packet("uni_self", 1'b0, PKT_UNI, 6'o32, 32'hA5A5_0002, 1'b1, 6'o32, 1);
  endtask

  task automatic test_row();
    test_packet("row", 1'b0, PKT_ROW, 6'o35, 32'h0000_0010, 1'b0, 6'o00, 7);
  endtask

  task automatic test_column();
    test_packet("col", 1'b0, PKT_COL, 6'o15, 32'h0000_0C01, 1'b1, 6'o75, 7);
  endtask

  task automatic test_bcast();
    test_packet("bcast", 1'b1, PKT_BCAST, 6'o00, 32'hB0B0_CAFE, 1'b1, 6'o76, 62);
  endtask

  task automatic test_back_to_back();
    int nvis, cyc;
    start_pkt(1'b0, PKT_ROW, 6'o44, 32'h1234_5678, 1'b0, 6'o00, 1'b1, nvis);
    sweep(1'b1, 1000, cyc);
    #1;
    cmp_cnt++;
    if (o_rdy !== 1'b1 || o_busy !== 1'b0 || o_cnt !== 7'd8) begin
      err_cnt++; $display("FAIL b2b_first_done: rdy=%b busy=%b cnt=%0d want 1/0/8", o_rdy, o_busy, o_cnt);
    end
    nvis = build(PKT_ROW, 6'o44, 1'b0, 6'o00, 6'o32);
    @(negedge clk);
    vld_a = 1'b0;
    #1;
    cmp_cnt++;
    if (o_busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_accept: busy=%b want 1", o_busy); end
    sweep(1'b1, 1000, cyc);
    #1;
    cmp_cnt++;
    if (o_cnt !== 7'd8 || q.size() != 0) begin
      err_cnt++; $display("FAIL b2b_second_done: cnt=%0d left=%0d want 8/0", o_cnt, q.size());
    end
  endtask

  task automatic test_reset_mid();
    int nvis, cyc;
    start_pkt(1'b1, PKT_BCAST, 6'o00, 32'hDEAD_0010, 1'b0, 6'o00, 1'b0, nvis);
    sweep(1'b0, 10, cyc);
    rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (ovld_b !== 1'b0 || rdy_b !== 1'b1 || busy_b !== 1'b0 || cnt_b !== 7'd0 ||
        tgt_b !== 6'd0 || last_b !== 1'b0 || data_b !== 32'd0 || typ_b !== 2'd0) begin
      err_cnt++;
      $display("FAIL mid_reset: vld=%b rdy=%b busy=%b cnt=%0d tgt=%o want 0/1/0/0/0", ovld_b, rdy_b, busy_b, cnt_b, tgt_b);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    test_packet("post_reset_uni", 1'b1, PKT_UNI, 6'o77, 32'h0BAD_F00D, 1'b0, 6'o00, 1);
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_row();
    test_column();
    test_bcast();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/mcast_replicate_ctrl.md
# mcast_replicate_ctrl

Sequencer for multicast and broadcast replication at a mesh node injection port. It accepts one packet header and payload on an input valid/ready handshake. It then emits one copy per destination on an output valid/ready handshake, walking the row, the column or the full 8x8 mesh, and skips an excluded node and, optionally, the local node. It sits between the node's local injection buffer and the router input, and owns target-coordinate stepping for replicated traffic.

## Interface
- LOCAL_X, 3'd0, X coordinate of this node (0-7)
- LOCAL_Y, 3'd0, Y coordinate of this node (0-7)
- DATA_W, 32, payload width
- SKIP_SELF, 1, when 1 replicated sweeps never emit a copy to {LOCAL_Y,LOCAL_X}
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_vld  in  1  packet offered
- in_rdy  out  1  controller can accept a packet
- in_type  in  2  00 unicast, 01 column multicast, 10 row multicast, 11 broadcast
- in_tgt  in  6  target {y[2:0],x[2:0]}
- in_data  in  DATA_W  payload
- skip_en  in  1  exclusion enable
- skip_node  in  6  excluded node {y,x}
- out_vld  out  1  copy valid
- out_rdy  in  1  downstream accepts copy
- out_tgt  out  6  destination of current copy
- out_type  out  2  latched in_type
- out_data  out  DATA_W  latched payload
- out_last  out  1  current copy is the final copy of the packet
- busy  out  1  sweep in progress
- copy_cnt  out  7  copies handshaken for current/last packet

## Operation
- States: IDLE, SEND. in_rdy = (state==IDLE). busy = (state==SEND).
- IDLE, in_vld: latch type, data, skip_en and skip_node (held constant for the whole sweep), init cursor, clear copy_cnt, go to SEND.
- Cursor init and sweep order:
  - 00: cursor=in_tgt, single position.
  - 01: x=in_tgt.x, y=0..7.
  - 10: y=in_tgt.y, x=0..7.
  - 11: {y,x}=0..63, increment x, carry into y on x wrap 7->0.
- skip(c) = (skip_en_l && c==skip_node_l) || (SKIP_SELF && c=={LOCAL_Y,LOCAL_X}). Unicast is never skipped.
- out_vld = SEND && !skip(cursor). out_tgt = cursor.
- Cursor advance, in SEND:
  - Skipped position: advance unconditionally; costs one cycle with out_vld=0.
  - Emitted position: advance only on out_vld && out_rdy.
- out_last = out_vld && no unskipped position remains after cursor. At most 2 positions are skippable, so check cursor+1 and cursor+2 against the sweep end. Unicast: always 1.
- SEND -> IDLE on out_vld && out_rdy && out_last. copy_cnt increments on every output handshake and holds its value in IDLE.
- out_tgt, out_data and out_type stay stable while out_vld=1 && out_rdy=0.
- All 8 (or 64) positions can never be skipped, so every packet emits at least 1 copy.

## Timing
- Reset: state=IDLE, in_rdy=1, out_vld=0, out_last=0, busy=0, copy_cnt=0, out_tgt=0, out_type=0, out_data=0.
- Accept in cycle N; first possible out_vld in N+1.
- No acceptance during SEND. The next packet is accepted at the earliest one cycle after the last handshake, giving one bubble per packet.
- Full sweep with out_rdy=1 and no skips takes 8 cycles (row/column) or 64 cycles (broadcast). Each skip adds 1 cycle.
- rst_n asserted mid-sweep: immediate return to IDLE, remaining copies discarded, outputs at reset values.
- skip_node/skip_en changes during SEND have no effect until the next acceptance.

## Structure
- Shared package mesh_pkg: PKT_UNI=2'b00, PKT_COL=2'b01, PKT_ROW=2'b10, PKT_BCAST=2'b11, COORD_W=3, NODE_W=6, MESH_DIM=8.
- Sub-module mcast_cursor: combinational next-position, sweep-end and skip lookahead (cursor+1, cursor+2) for a given type/cursor/skip set. The FSM, registers and counters stay in the top.

## Test plan
- Unicast type 00, tgt 6'o52, out_rdy=1 -> one copy, out_tgt=6'o52, out_last=1, copy_cnt=1, in_rdy back to 1 next cycle.
- Row type 10, tgt y=3, LOCAL=(2,3), SKIP_SELF=1, skip_en=0 -> 7 copies x=0,1,3..7 at y=3, bubble at x=2, out_last on x=7.
- Column type 01, x=5, skip_node={7,5}, skip_en=1, node (0,0) -> 8 positions minus y=7 gives copies y=0..6, out_last on y=6.
- Broadcast from node (7,7), skip_node=6'o76 -> 62 copies in row-major order, out_last on 6'o75, copy_cnt=62.
- Backpressure: row sweep with out_rdy toggled randomly -> outputs stable while stalled, no duplicate or missing x; in_vld held high is not accepted until IDLE.
- Reset asserted after the 10th broadcast copy -> out_vld=0 and in_rdy=1 immediately. A following unicast completes normally.
